// File: rtl/bp_nonsynth_host_io_arbiter_if.sv
// rtl/bp_nonsynth_host_io_arbiter_if.sv - requester and host links of the host I/O arbiter
interface bp_nonsynth_host_io_arbiter_if #(
    parameter int num_req_p   = 2,
    parameter int msg_width_p = 128,
    parameter int tag_els_p   = 4
);
    localparam int cnt_width_lp = $clog2(tag_els_p + 1);

    logic [num_req_p*msg_width_p-1:0] req_cmd_i;
    logic [num_req_p-1:0]             req_cmd_v_i;
    logic [num_req_p-1:0]             req_cmd_ready_o;
    logic [num_req_p*msg_width_p-1:0] req_resp_o;
    logic [num_req_p-1:0]             req_resp_v_o;
    logic [num_req_p-1:0]             req_resp_yumi_i;
    logic [msg_width_p-1:0]           host_cmd_o;
    logic                             host_cmd_v_o;
    logic                             host_cmd_ready_i;
    logic [msg_width_p-1:0]           host_resp_i;
    logic                             host_resp_v_i;
    logic                             host_resp_yumi_o;
    logic [cnt_width_lp-1:0]          outstanding_o;

    modport slave (
        input  req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
        input  host_cmd_ready_i, host_resp_i, host_resp_v_i,
        output req_cmd_ready_o, req_resp_o, req_resp_v_o,
        output host_cmd_o, host_cmd_v_o, host_resp_yumi_o, outstanding_o
    );

    modport master (
        output req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
        output host_cmd_ready_i, host_resp_i, host_resp_v_i,
        input  req_cmd_ready_o, req_resp_o, req_resp_v_o,
        input  host_cmd_o, host_cmd_v_o, host_resp_yumi_o, outstanding_o
    );
endinterface

// File: rtl/bp_nonsynth_host_io_arbiter.sv
// rtl/bp_nonsynth_host_io_arbiter.sv - round-robin host I/O arbiter with in-order tag return; trace under BP_NONSYNTH_HOST_ARB_TRACE_EN
module bp_nonsynth_host_io_arbiter #(
    parameter int num_req_p   = 2,
    parameter int msg_width_p = 128,
    parameter int tag_els_p   = 4
) (
    input logic                           clk_i,
    input logic                           reset_i,
    bp_nonsynth_host_io_arbiter_if.slave  io
);
    localparam int idx_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int tag_ptr_width_lp = $clog2(tag_els_p);
    localparam int cnt_width_lp = $clog2(tag_els_p + 1);

    logic [idx_width_lp-1:0]     ptr_q, ptr_d;
    logic [idx_width_lp-1:0]     tag_mem_q [tag_els_p];
    logic [idx_width_lp-1:0]     tag_mem_d [tag_els_p];
    logic [tag_ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [tag_ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_width_lp-1:0]     count_q, count_d;

    logic                    tag_full, tag_empty;
    logic [idx_width_lp-1:0] head;
    logic [num_req_p-1:0]    eligible, rot;
    logic [idx_width_lp:0]   sum;
    logic [idx_width_lp-1:0] grant, grant_next;
    logic                    cmd_v, cmd_xfer;
    logic                    resp_v, resp_yumi;
    logic                    resp_proto_err;

    assign tag_full  = (count_q == cnt_width_lp'(tag_els_p));
    assign tag_empty = (count_q == '0);
    assign head      = tag_mem_q[rd_ptr_q];

    // Rotate so that bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        eligible = io.req_cmd_v_i & {num_req_p{~tag_full}};
        rot      = num_req_p'({eligible, eligible} >> ptr_q);
        grant    = '0;
        sum      = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_q} + (idx_width_lp + 1)'(i);
            if (sum >= (idx_width_lp + 1)'(num_req_p))
                sum = sum - (idx_width_lp + 1)'(num_req_p);
            if (rot[i])
                grant = sum[idx_width_lp-1:0];
        end
    end

    assign cmd_v      = |eligible;
    assign cmd_xfer   = cmd_v & io.host_cmd_ready_i;
    assign grant_next = (grant == idx_width_lp'(num_req_p - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        io.req_cmd_ready_o        = '0;
        io.req_cmd_ready_o[grant] = cmd_xfer;
    end

    assign io.host_cmd_v_o = cmd_v;
    assign io.host_cmd_o   = io.req_cmd_i[grant*msg_width_p +: msg_width_p];

    assign resp_v         = io.host_resp_v_i & ~tag_empty;
    assign resp_yumi      = resp_v & io.req_resp_yumi_i[head];
    assign resp_proto_err = io.host_resp_v_i & tag_empty;

    always_comb begin
        io.req_resp_v_o       = '0;
        io.req_resp_v_o[head] = resp_v;
    end

    assign io.req_resp_o       = {num_req_p{io.host_resp_i}};
    assign io.host_resp_yumi_o = resp_yumi;
    assign io.outstanding_o    = count_q;

    always_comb begin
        ptr_d    = ptr_q;
        tag_mem_d = tag_mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (cmd_xfer) begin
            tag_mem_d[wr_ptr_q] = grant;
            wr_ptr_d = (wr_ptr_q == tag_ptr_width_lp'(tag_els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
            ptr_d    = grant_next;
        end
        if (resp_yumi)
            rd_ptr_d = (rd_ptr_q == tag_ptr_width_lp'(tag_els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({cmd_xfer, resp_yumi})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Tag contents need no reset: the pointers and count alone decide validity.
    always_ff @(posedge clk_i) begin
        tag_mem_q <= tag_mem_d;
        if (reset_i) begin
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!reset_i && resp_proto_err)
            $warning("[HOSTARB] host response with no outstanding tag");
    end
`endif

`ifdef BP_NONSYNTH_HOST_ARB_TRACE_EN
    localparam int addr_width_lp = (msg_width_p < 40) ? msg_width_p : 40;

    always @(negedge clk_i) begin
        if (!reset_i && cmd_xfer)
            $display("[HOSTARB] grant req%0d addr=%h", grant, io.host_cmd_o[addr_width_lp-1:0]);
        if (!reset_i && resp_yumi)
            $display("[HOSTARB] resp req%0d", head);
    end
`endif

endmodule

// File: tb/tb_bp_nonsynth_host_io_arbiter.sv
// tb/tb_bp_nonsynth_host_io_arbiter.sv - directed bench for the host I/O arbiter
module tb_bp_nonsynth_host_io_arbiter;
    localparam int N = 2;
    localparam int W = 128;
    localparam int T = 4;
    localparam logic [W-1:0] CMD0 = 128'h0000_0000_0000_0000_0000_00A0_0000_1000;
    localparam logic [W-1:0] CMD1 = 128'h0000_0000_0000_0000_0000_00B1_0000_2000;
    localparam logic [W-1:0] RESP = 128'hDEAD_BEEF_0000_0000_1234_5678_9ABC_DEF0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bp_nonsynth_host_io_arbiter_if #(.num_req_p(N), .msg_width_p(W), .tag_els_p(T)) bus ();

    bp_nonsynth_host_io_arbiter #(.num_req_p(N), .msg_width_p(W), .tag_els_p(T)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .io      (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fail(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_cmd_i        = {CMD1, CMD0};
        bus.req_cmd_v_i      = '0;
        bus.req_resp_yumi_i  = '0;
        bus.host_cmd_ready_i = 1'b0;
        bus.host_resp_i      = RESP;
        bus.host_resp_v_i    = 1'b0;
        tick;
        tick;
        #1;
        checks++; if (bus.req_cmd_ready_o !== 2'b00) fail("rst_cmd_ready", bus.req_cmd_ready_o, 2'b00);
        checks++; if (bus.req_resp_v_o !== 2'b00) fail("rst_resp_v", bus.req_resp_v_o, 2'b00);
        checks++; if (bus.host_cmd_v_o !== 1'b0) fail("rst_host_cmd_v", bus.host_cmd_v_o, 1'b0);
        checks++; if (bus.host_resp_yumi_o !== 1'b0) fail("rst_host_yumi", bus.host_resp_yumi_o, 1'b0);
        checks++; if (bus.outstanding_o !== 3'd0) fail("rst_outstanding", bus.outstanding_o, 3'd0);
        checks++; if (dut.ptr_q !== 1'b0) fail("rst_ptr", dut.ptr_q, 1'b0);
        rst = 1'b0;
        tick;

        bus.req_cmd_v_i      = 2'b11;
        bus.host_cmd_ready_i = 1'b1;
        bus.req_resp_yumi_i  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            bus.host_resp_v_i = (i > 0);
            #1;
            checks++; if (bus.req_cmd_ready_o !== ((i % 2 == 0) ? 2'b01 : 2'b10)) fail("t1_cmd_ready", bus.req_cmd_ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            checks++; if (bus.host_cmd_o !== ((i % 2 == 0) ? CMD0 : CMD1)) fail("t1_host_cmd", bus.host_cmd_o, (i % 2 == 0) ? CMD0 : CMD1);
            if (i > 0) begin
                checks++; if (bus.req_resp_v_o !== ((i % 2 == 1) ? 2'b01 : 2'b10)) fail("t1_resp_v", bus.req_resp_v_o, (i % 2 == 1) ? 2'b01 : 2'b10);
            end
            tick;
        end
        bus.req_cmd_v_i = 2'b00;
        #1;
        checks++; if (bus.req_resp_v_o !== 2'b10) fail("t1_drain_resp_v", bus.req_resp_v_o, 2'b10);
        tick;
        bus.host_resp_v_i   = 1'b0;
        bus.req_resp_yumi_i = 2'b00;
        #1;
        checks++; if (bus.outstanding_o !== 3'd0) fail("t1_outstanding", bus.outstanding_o, 3'd0);

        bus.req_cmd_v_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.req_cmd_ready_o !== ((i % 2 == 0) ? 2'b01 : 2'b10)) fail("t2_cmd_ready", bus.req_cmd_ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick;
        end
        #1;
        checks++; if (bus.outstanding_o !== 3'd4) fail("t2_full_outstanding", bus.outstanding_o, 3'd4);
        checks++; if (bus.host_cmd_v_o !== 1'b0) fail("t2_full_cmd_v", bus.host_cmd_v_o, 1'b0);
        checks++; if (bus.req_cmd_ready_o !== 2'b00) fail("t2_full_cmd_ready", bus.req_cmd_ready_o, 2'b00);
        bus.host_resp_v_i   = 1'b1;
        bus.req_resp_yumi_i = 2'b01;
        #1;
        checks++; if (bus.host_resp_yumi_o !== 1'b1) fail("t2_deq_yumi", bus.host_resp_yumi_o, 1'b1);
        checks++; if (bus.host_cmd_v_o !== 1'b0) fail("t2_deq_slip_cmd_v", bus.host_cmd_v_o, 1'b0);
        tick;
        bus.host_resp_v_i   = 1'b0;
        bus.req_resp_yumi_i = 2'b00;
        #1;
        checks++; if (bus.outstanding_o !== 3'd3) fail("t2_after_deq_outstanding", bus.outstanding_o, 3'd3);
        checks++; if (bus.req_cmd_ready_o !== 2'b01) fail("t2_after_deq_cmd_ready", bus.req_cmd_ready_o, 2'b01);
        tick;
        bus.req_cmd_v_i     = 2'b00;
        bus.host_resp_v_i   = 1'b1;
        bus.req_resp_yumi_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.req_resp_v_o !== ((i % 2 == 0) ? 2'b10 : 2'b01)) fail("t2_drain_resp_v", bus.req_resp_v_o, (i % 2 == 0) ? 2'b10 : 2'b01);
            tick;
        end
        bus.host_resp_v_i   = 1'b0;
        bus.req_resp_yumi_i = 2'b00;
        #1;
        checks++; if (bus.outstanding_o !== 3'd0) fail("t2_drained", bus.outstanding_o, 3'd0);

        bus.req_cmd_v_i = 2'b10;
        #1;
        checks++; if (bus.req_cmd_ready_o !== 2'b10) fail("t3_cmd1_ready", bus.req_cmd_ready_o, 2'b10);
        checks++; if (bus.host_cmd_o !== CMD1) fail("t3_cmd1_data", bus.host_cmd_o, CMD1);
        tick;
        bus.req_cmd_v_i = 2'b01;
        #1;
        checks++; if (bus.req_cmd_ready_o !== 2'b01) fail("t3_cmd0_ready", bus.req_cmd_ready_o, 2'b01);
        checks++; if (bus.host_cmd_o !== CMD0) fail("t3_cmd0_data", bus.host_cmd_o, CMD0);
        tick;
        bus.req_cmd_v_i     = 2'b00;
        bus.host_resp_v_i   = 1'b1;
        bus.req_resp_yumi_i = 2'b01;
        #1;
        checks++; if (bus.req_resp_v_o !== 2'b10) fail("t3_resp1_v", bus.req_resp_v_o, 2'b10);
        checks++; if (bus.host_resp_yumi_o !== 1'b0) fail("t3_resp1_wrong_yumi", bus.host_resp_yumi_o, 1'b0);
        checks++; if (bus.req_resp_o[2*W-1:W] !== RESP) fail("t3_resp1_data", bus.req_resp_o[2*W-1:W], RESP);
        tick;
        #1;
        checks++; if (bus.outstanding_o !== 3'd2) fail("t3_hold_outstanding", bus.outstanding_o, 3'd2);
        bus.req_resp_yumi_i = 2'b10;
        #1;
        checks++; if (bus.host_resp_yumi_o !== 1'b1) fail("t3_resp1_yumi", bus.host_resp_yumi_o, 1'b1);
        tick;
        #1;
        checks++; if (bus.req_resp_v_o !== 2'b01) fail("t3_resp0_v", bus.req_resp_v_o, 2'b01);
        checks++; if (bus.host_resp_yumi_o !== 1'b0) fail("t3_resp0_wrong_yumi", bus.host_resp_yumi_o, 1'b0);
        tick;
        bus.req_resp_yumi_i = 2'b01;
        #1;
        checks++; if (bus.host_resp_yumi_o !== 1'b1) fail("t3_resp0_yumi", bus.host_resp_yumi_o, 1'b1);
        tick;
        bus.host_resp_v_i   = 1'b0;
        bus.req_resp_yumi_i = 2'b00;
        #1;
        checks++; if (bus.outstanding_o !== 3'd0) fail("t3_outstanding", bus.outstanding_o, 3'd0);

        bus.req_cmd_v_i = 2'b10;
        tick;
        #1;
        checks++; if (dut.ptr_q !== 1'b0) fail("t4_ptr_start", dut.ptr_q, 1'b0);
        bus.host_cmd_ready_i = 1'b0;
        bus.req_cmd_v_i      = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.host_cmd_v_o !== 1'b1) fail("t4_stall_cmd_v", bus.host_cmd_v_o, 1'b1);
            checks++; if (bus.req_cmd_ready_o !== 2'b00) fail("t4_stall_cmd_ready", bus.req_cmd_ready_o, 2'b00);
            tick;
            #1;
            checks++; if (dut.ptr_q !== 1'b0) fail("t4_stall_ptr", dut.ptr_q, 1'b0);
        end
        bus.host_cmd_ready_i = 1'b1;
        #1;
        checks++; if (bus.req_cmd_ready_o !== 2'b01) fail("t4_xfer_ready", bus.req_cmd_ready_o, 2'b01);
        tick;
        bus.req_cmd_v_i = 2'b00;
        #1;
        checks++; if (dut.ptr_q !== 1'b1) fail("t4_ptr_after", dut.ptr_q, 1'b1);
        checks++; if (bus.outstanding_o !== 3'd2) fail("t4_outstanding", bus.outstanding_o, 3'd2);

        bus.host_resp_v_i = 1'b1;
        #1;
        checks++; if (bus.req_resp_v_o !== 2'b10) fail("t5_pre_resp_v", bus.req_resp_v_o, 2'b10);
        rst = 1'b1;
        tick;
        #1;
        checks++; if (bus.outstanding_o !== 3'd0) fail("t5_outstanding", bus.outstanding_o, 3'd0);
        checks++; if (dut.ptr_q !== 1'b0) fail("t5_ptr", dut.ptr_q, 1'b0);
        checks++; if (bus.req_resp_v_o !== 2'b00) fail("t5_resp_v", bus.req_resp_v_o, 2'b00);
        checks++; if (bus.host_resp_yumi_o !== 1'b0) fail("t5_host_yumi", bus.host_resp_yumi_o, 1'b0);
        checks++; if (bus.host_cmd_v_o !== 1'b0) fail("t5_host_cmd_v", bus.host_cmd_v_o, 1'b0);
        checks++; if (bus.req_cmd_ready_o !== 2'b00) fail("t5_cmd_ready", bus.req_cmd_ready_o, 2'b00);
        bus.host_resp_v_i = 1'b0;
        rst = 1'b0;
        tick;

        bus.host_resp_v_i   = 1'b1;
        bus.req_resp_yumi_i = 2'b11;
        #1;
        checks++; if (bus.req_resp_v_o !== 2'b00) fail("t6_resp_v", bus.req_resp_v_o, 2'b00);
        checks++; if (bus.host_resp_yumi_o !== 1'b0) fail("t6_host_yumi", bus.host_resp_yumi_o, 1'b0);
        checks++; if (dut.resp_proto_err !== 1'b1) fail("t6_proto_err", dut.resp_proto_err, 1'b1);
        tick;
        bus.host_resp_v_i   = 1'b0;
        bus.req_resp_yumi_i = 2'b00;
        #1;
        checks++; if (bus.outstanding_o !== 3'd0) fail("t6_outstanding", bus.outstanding_o, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
